// File: rtl/quad_updown_decoder.sv
// Quadrature up/down decoder: synchronizes phases A/B, decodes Gray-code steps
// into a wrapping position count with step/ovf/unf pulses and a sticky error flag.
module quad_updown_decoder #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_in,
    input  logic            b_in,
    input  logic            en,
    input  logic            clr,
    output logic [SIZE-1:0] count,
    output logic            dir_up,
    output logic            step,
    output logic            ovf,
    output logic            unf,
    output logic            err
);

    typedef enum logic {
        SETTLE,
        RUN
    } state_t;

    localparam logic [SIZE-1:0] CNT_MAX = {SIZE{1'b1}};
    localparam logic [SIZE-1:0] CNT_ONE = {{(SIZE-1){1'b0}}, 1'b1};

    state_t          state_q;
    logic [1:0]      settle_cnt_q;
    logic [1:0]      sync1_q;
    logic [1:0]      s_q;
    logic [1:0]      p_q;
    logic [SIZE-1:0] count_q;
    logic            dir_q;
    logic            step_q;
    logic            ovf_q;
    logic            unf_q;
    logic            err_q;

    logic            is_up;
    logic            is_dn;
    logic            is_bad;
    logic [SIZE-1:0] count_inc_d;
    logic [SIZE-1:0] count_dec_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        is_up = 1'b0;
        is_dn = 1'b0;
        case ({p_q, s_q})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_up = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: is_dn = 1'b1;
            default: ;
        endcase
        is_bad      = ((p_q ^ s_q) == 2'b11);
        count_inc_d = count_q + CNT_ONE;
        count_dec_d = count_q - CNT_ONE;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SETTLE;
            settle_cnt_q <= 2'd0;
            sync1_q      <= 2'b00;
            s_q          <= 2'b00;
            p_q          <= 2'b00;
            count_q      <= '0;
            dir_q        <= 1'b1;
            step_q       <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            sync1_q <= {a_in, b_in};
            s_q     <= sync1_q;
            p_q     <= s_q;
            step_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;

            // Synchronizer and p hold reset garbage for three cycles; ignore them.
            if (state_q == SETTLE) begin
                if (settle_cnt_q == 2'd2) begin
                    state_q <= RUN;
                end else begin
                    settle_cnt_q <= settle_cnt_q + 2'd1;
                end
            end

            if (clr) begin
                count_q <= '0;
                err_q   <= 1'b0;
            end else if (state_q == RUN) begin
                if (is_bad) begin
                    err_q <= 1'b1;
                end
                if (en && is_up) begin
                    count_q <= count_inc_d;
                    dir_q   <= 1'b1;
                    step_q  <= 1'b1;
                    ovf_q   <= (count_q == CNT_MAX);
                end else if (en && is_dn) begin
                    count_q <= count_dec_d;
                    dir_q   <= 1'b0;
                    step_q  <= 1'b1;
                    unf_q   <= (count_q == '0);
                end
            end
        end
    end

    assign count  = count_q;
    assign dir_up = dir_q;
    assign step   = step_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;
    assign err    = err_q;

endmodule

// File: tb/tb_quad_updown_decoder.sv
// Directed bench for quad_updown_decoder: hand-computed counts, pulses and flags.
module tb_quad_updown_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_in;
    logic       b_in;
    logic       en;
    logic       clr;
    logic [7:0] count;
    logic       dir_up;
    logic       step;
    logic       ovf;
    logic       unf;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_count = 8'd0;

    quad_updown_decoder #(.SIZE(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .a_in   (a_in),
        .b_in   (b_in),
        .en     (en),
        .clr    (clr),
        .count  (count),
        .dir_up (dir_up),
        .step   (step),
        .ovf    (ovf),
        .unf    (unf),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one input change, then checks latency, result and pulse width over 5 cycles.
    task automatic edge_check(input string tag, input logic [1:0] ab, input logic [7:0] new_count,
                              input logic exp_step, input logic exp_ovf, input logic exp_unf,
                              input logic exp_dir);
        {a_in, b_in} = ab;
        tick(2);
        check({tag, "_early_cnt"}, 32'(count), 32'(exp_count));
        check({tag, "_early_step"}, 32'(step), 32'd0);
        tick(1);
        check({tag, "_cnt"}, 32'(count), 32'(new_count));
        check({tag, "_step"}, 32'(step), 32'(exp_step));
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        check({tag, "_unf"}, 32'(unf), 32'(exp_unf));
        check({tag, "_dir"}, 32'(dir_up), 32'(exp_dir));
        tick(1);
        check({tag, "_step_end"}, 32'(step), 32'd0);
        tick(1);
        exp_count = new_count;
    endtask

    initial begin
        rst = 1'b1; a_in = 1'b0; b_in = 1'b0; en = 1'b1; clr = 1'b0;
        tick(3);
        check("rst_cnt", 32'(count), 32'd0);
        check("rst_dir", 32'(dir_up), 32'd1);
        check("rst_step", 32'(step), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick(4);

        // Four forward steps.
        edge_check("fwd1", 2'b10, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        edge_check("fwd2", 2'b11, 8'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        edge_check("fwd3", 2'b01, 8'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        edge_check("fwd4", 2'b00, 8'd4, 1'b1, 1'b0, 1'b0, 1'b1);

        // Underflow then overflow around zero.
        clr = 1'b1; tick(1); clr = 1'b0;
        check("clr_cnt", 32'(count), 32'd0);
        exp_count = 8'd0;
        edge_check("unf", 2'b01, 8'd255, 1'b1, 1'b0, 1'b1, 1'b0);
        edge_check("ovf", 2'b00, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1);

        // Illegal double change sets sticky err; clr removes it.
        edge_check("pre_bad", 2'b10, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        {a_in, b_in} = 2'b01;
        tick(2);
        check("bad_err_early", 32'(err), 32'd0);
        tick(1);
        check("bad_err", 32'(err), 32'd1);
        check("bad_cnt", 32'(count), 32'd1);
        check("bad_step", 32'(step), 32'd0);
        tick(4);
        check("bad_sticky", 32'(err), 32'd1);
        clr = 1'b1; tick(1); clr = 1'b0;
        check("bad_clr_err", 32'(err), 32'd0);
        check("bad_clr_cnt", 32'(count), 32'd0);
        exp_count = 8'd0;

        // Disabled counting still tracks phase.
        en = 1'b0;
        edge_check("dis1", 2'b00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        edge_check("dis2", 2'b10, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        en = 1'b1;
        edge_check("ena", 2'b11, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1);

        // clr lands on the very cycle the step would register.
        {a_in, b_in} = 2'b01;
        tick(2);
        clr = 1'b1; tick(1); clr = 1'b0;
        check("clrstep_cnt", 32'(count), 32'd0);
        check("clrstep_step", 32'(step), 32'd0);
        check("clrstep_err", 32'(err), 32'd0);
        check("clrstep_dir", 32'(dir_up), 32'd1);
        tick(2);
        exp_count = 8'd0;
        edge_check("pre_rst", 2'b00, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Inputs jump to 11 and stay there across reset release.
        {a_in, b_in} = 2'b11;
        rst = 1'b1;
        tick(3);
        check("rst2_cnt", 32'(count), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("hold11_step", 32'(step), 32'd0);
            check("hold11_err", 32'(err), 32'd0);
            check("hold11_cnt", 32'(count), 32'd0);
        end
        exp_count = 8'd0;
        edge_check("post_rst", 2'b01, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("post_rst_err", 32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
